ahb_button_event_queue: RTL and testbench
=========================================

// Module: ahb_button_event_queue
// PURPOSE
// - AHB-Lite slave; debounces N_BTN active-low buttons and classifies each press as SHORT, DOUBLE or LONG.
// - Pushes {chan,code} events into a FIFO that software pops through a read-to-pop register.
// - Raises IRQ while the FIFO is non-empty. Generalised successor of the two-button manager.
// - Sits on the peripheral AHB bus beside the display and wheel-sensor slaves.
// PARAMETERS
// - N_BTN       4      button channels, 1..8
// - DEB_CYC     900    stable cycles required to accept a level change (25 ms @ 36 kHz)
// - LONG_CYC    32000  held cycles, counted after press debounce, that make a LONG event
// - GAP_CYC     16000  window after a release in which a second press makes DOUBLE
// - FIFO_DEPTH  8      event entries, power of 2, 2..16
// PORTS
// - HCLK       in   1      AHB clock
// - HRESETn    in   1      AHB reset; asynchronous, active-low
// - HSEL, HREADY, HWRITE   in  1   standard AHB-Lite controls
// - HTRANS     in   2      standard AHB-Lite transfer type
// - HSIZE      in   3      standard AHB-Lite size; word only, ignored
// - HADDR      in   32     only [3:2] decoded
// - HWDATA     in   32     write data, data phase
// - Btn        in   N_BTN  raw buttons, 0 = pressed, asynchronous
// - HRDATA     out  32     read data
// - HREADYOUT  out  1      tied 1, zero wait states
// - IRQ        out  1      = IE & ~empty, registered
// BEHAVIOUR
// - Reset: HRDATA=0, IRQ=0, FIFO empty, OVF=0, IE=0, all channels IDLE, debounced level=released.
// - Btn goes through a 2-flop synchroniser. A debounce counter restarts on any change of the synced level.
// - The debounced level updates after DEB_CYC stable cycles.
// - Channel FSM (transitions on debounced edges):
//   - IDLE -press-> HELD
//   - HELD -release, held<LONG_CYC-> GAP
//   - HELD -held reaches LONG_CYC-> emit LONG, go to WAIT_REL
//   - WAIT_REL -release-> IDLE
//   - GAP -press within GAP_CYC-> emit DOUBLE, go to WAIT_REL
//   - GAP -GAP_CYC expires-> emit SHORT, go to IDLE
// - Codes: SHORT=1, DOUBLE=2, LONG=3; 0 = no event.
// - Each channel holds one pending event plus a valid flag until the arbiter accepts it.
// - A new event arriving while one is still pending overwrites it and sets that channel's LOST bit (part of OVF).
// - Arbiter: fixed priority, lowest channel index first; at most one push per cycle.
// - Push while full: event dropped, OVF set (sticky).
// - Push and pop in the same cycle while full: both complete, count unchanged.
// - Bus: the address phase is registered when HSEL & HREADY & HTRANS[1]; the read mux is combinational on the registered address.
// - Register map:
//   - 0x0: STATUS (RO) — [0]=~empty, [1]=OVF, [7:4]=count
//   - 0x4: EVENT (RO, pop) — [31]=valid, [10:8]=chan, [1:0]=code. A read pops in its data phase. A read while empty returns 0 and has no side effect.
//   - 0x8: CTRL — [0]=IE (RW); write [1]=1 clears OVF (W1C). OVF set and clear in the same cycle: set wins.
//   - 0xC: LEVEL (RO) — [N_BTN-1:0] debounced pressed levels, 1 = pressed.
// - Writes to RO registers are ignored. Reads of unused bits return 0.
// - Count wraps never: saturates at FIFO_DEPTH, pointer arithmetic is modulo FIFO_DEPTH.
// - A press shorter than DEB_CYC produces no event. A release shorter than DEB_CYC is ignored, so the press continues.
// STRUCTURE
// - Package button_pkg: evt_code_t enum (NONE, SHORT, DOUBLE, LONG); chan_state_t enum (IDLE, HELD, WAIT_REL, GAP); register offset localparams.
// - Sub-module button_channel: synchroniser, debounce, FSM and pending slot. Instantiated N_BTN times with generate.
// - The FIFO, arbiter and AHB decode live in the top level.
// TESTING
// - Short press: 2000 cycles on ch1, then release, wait GAP_CYC+10 -> EVENT reads 0x8000_0101, IRQ=1 when IE=1, IRQ=0 after the pop.
// - Double press: ch0 pressed 2000, released 3000, pressed 2000 -> a single EVENT 0x8000_0002, and no SHORT.
// - Long press: ch2 held 40000 cycles -> LONG (0x8000_0203) pushed at DEB_CYC+LONG_CYC; the release adds no event.
// - Bounce: 10 pulses of 100 cycles, then a steady press -> exactly one event; a 500-cycle glitch alone -> none.
// - Simultaneous: ch3 and ch0 emit in the same cycle -> pop order ch0 then ch3.
// - Overflow: 9 events with FIFO_DEPTH=8 -> count=8, OVF=1; W1C clears OVF; HRESETn low mid-press -> all state back to reset values.

Source files
------------

// File: rtl/button_pkg.sv
// ---------------------------------------------------------------------------
// button_pkg
// Shared types and constants for the AHB button event queue.
//   evt_code_t   : event code carried in the EVENT register (0 = no event)
//   chan_state_t : per-channel press classification state
//   evt_entry_t  : one FIFO entry, {channel index, event code}
//   REG_*        : register offsets as decoded from HADDR[3:2]
//   pack_event   : builds the 32-bit EVENT read word from a FIFO entry
// ---------------------------------------------------------------------------
package button_pkg;

   typedef enum logic [1:0] {
      NONE   = 2'd0,
      SHORT  = 2'd1,
      DOUBLE = 2'd2,
      LONG   = 2'd3
   } evt_code_t;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      HELD     = 2'd1,
      WAIT_REL = 2'd2,
      GAP      = 2'd3
   } chan_state_t;

   typedef struct packed {
      logic [2:0] chan;
      evt_code_t  code;
   } evt_entry_t;

   localparam logic [1:0] REG_STATUS = 2'd0;
   localparam logic [1:0] REG_EVENT  = 2'd1;
   localparam logic [1:0] REG_CTRL   = 2'd2;
   localparam logic [1:0] REG_LEVEL  = 2'd3;

   // EVENT word layout: [31]=valid, [10:8]=chan, [1:0]=code, all else 0.
   function automatic logic [31:0] pack_event(input evt_entry_t entry);
      return {1'b1, 20'd0, entry.chan, 6'd0, entry.code};
   endfunction

endpackage

// File: rtl/button_channel.sv
// ---------------------------------------------------------------------------
// button_channel
// One button: 2-flop synchroniser, debounce filter, press classifier FSM and
// a single-entry pending event slot that the top-level arbiter drains.
// Ports:
//   HCLK, HRESETn : clock, asynchronous active-low reset
//   btn_n         : raw button, 0 = pressed, asynchronous
//   accept        : arbiter takes the pending event this cycle
//   clr_lost      : clear the LOST flag (software W1C of OVF)
//   level         : debounced level, 1 = pressed
//   pend_valid    : a pending event is waiting
//   pend_code     : code of the pending event
//   lost          : a pending event was overwritten before being accepted
// ---------------------------------------------------------------------------
module button_channel
   import button_pkg::*;
#(
   parameter int DEB_CYC  = 900,
   parameter int LONG_CYC = 32000,
   parameter int GAP_CYC  = 16000
) (
   input  logic      HCLK,
   input  logic      HRESETn,
   input  logic      btn_n,
   input  logic      accept,
   input  logic      clr_lost,
   output logic      level,
   output logic      pend_valid,
   output evt_code_t pend_code,
   output logic      lost
);

   localparam int TMR_MAX = (LONG_CYC > GAP_CYC) ? LONG_CYC : GAP_CYC;
   localparam int DEB_W   = $clog2(DEB_CYC + 1);
   localparam int TMR_W   = $clog2(TMR_MAX + 1);

   localparam logic [DEB_W-1:0] DEB_LAST  = DEB_W'(DEB_CYC - 1);
   localparam logic [TMR_W-1:0] LONG_LAST = TMR_W'(LONG_CYC - 1);
   localparam logic [TMR_W-1:0] GAP_LAST  = TMR_W'(GAP_CYC - 1);

   logic [1:0]       sync_q;
   logic             pressed_sync;
   logic [DEB_W-1:0] deb_cnt_q;
   logic             level_q;

   chan_state_t      state_q, state_d;
   logic [TMR_W-1:0] tmr_q, tmr_d;
   logic             emit;
   evt_code_t        emit_code;

   logic             pend_valid_q;
   evt_code_t        pend_code_q;
   logic             lost_q;

   // Two-flop synchroniser; resets to the released (high) level so that no
   // spurious press is seen coming out of reset.
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         sync_q <= 2'b11;
      end else begin
         sync_q <= {sync_q[0], btn_n};
      end
   end

   assign pressed_sync = ~sync_q[1];

   // Debounce: the counter only runs while the synced level disagrees with
   // the accepted level. Because the level is binary, any change of the
   // synced level during a run makes it agree again, which restarts the
   // count, so a level is accepted only after DEB_CYC unbroken cycles.
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         deb_cnt_q <= '0;
         level_q   <= 1'b0;
      end else if (pressed_sync == level_q) begin
         deb_cnt_q <= '0;
      end else if (deb_cnt_q == DEB_LAST) begin
         deb_cnt_q <= '0;
         level_q   <= pressed_sync;
      end else begin
         deb_cnt_q <= deb_cnt_q + 1'b1;
      end
   end

   // Classifier state register. The timer measures held time in HELD and
   // the double-press window in GAP.
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         state_q <= IDLE;
         tmr_q   <= '0;
      end else begin
         state_q <= state_d;
         tmr_q   <= tmr_d;
      end
   end

   // Classifier next-state logic. Each state implies the debounced level it
   // was entered with, so testing the level here acts on debounced edges.
   always_comb begin
      state_d   = state_q;
      tmr_d     = tmr_q;
      emit      = 1'b0;
      emit_code = NONE;
      case (state_q)
         IDLE: begin
            if (level_q) begin
               state_d = HELD;
               tmr_d   = '0;
            end
         end
         HELD: begin
            if (!level_q) begin
               state_d = GAP;
               tmr_d   = '0;
            end else if (tmr_q == LONG_LAST) begin
               emit      = 1'b1;
               emit_code = LONG;
               state_d   = WAIT_REL;
            end else begin
               tmr_d = tmr_q + 1'b1;
            end
         end
         WAIT_REL: begin
            if (!level_q) begin
               state_d = IDLE;
            end
         end
         GAP: begin
            if (level_q) begin
               emit      = 1'b1;
               emit_code = DOUBLE;
               state_d   = WAIT_REL;
            end else if (tmr_q == GAP_LAST) begin
               emit      = 1'b1;
               emit_code = SHORT;
               state_d   = IDLE;
            end else begin
               tmr_d = tmr_q + 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
            tmr_d   = '0;
         end
      endcase
   end

   // Pending slot. A new event always wins the slot; if the previous one was
   // still waiting and not taken this very cycle it is lost and flagged.
   // Setting LOST takes priority over a simultaneous software clear.
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         pend_valid_q <= 1'b0;
         pend_code_q  <= NONE;
         lost_q       <= 1'b0;
      end else begin
         if (emit) begin
            pend_valid_q <= 1'b1;
            pend_code_q  <= emit_code;
         end else if (accept) begin
            pend_valid_q <= 1'b0;
         end
         if (emit && pend_valid_q && !accept) begin
            lost_q <= 1'b1;
         end else if (clr_lost) begin
            lost_q <= 1'b0;
         end
      end
   end

   assign level      = level_q;
   assign pend_valid = pend_valid_q;
   assign pend_code  = pend_code_q;
   assign lost       = lost_q;

endmodule

// File: rtl/ahb_button_event_queue.sv
// ---------------------------------------------------------------------------
// ahb_button_event_queue
// AHB-Lite slave that debounces N_BTN active-low buttons, classifies each
// press as SHORT, DOUBLE or LONG and queues {chan,code} events in a FIFO
// which software drains through a read-to-pop register.
// Ports:
//   HCLK, HRESETn      : AHB clock, asynchronous active-low reset
//   HSEL, HREADY       : slave select, bus ready
//   HWRITE, HTRANS     : transfer direction and type
//   HSIZE              : transfer size (word accesses assumed, ignored)
//   HADDR              : address, only [3:2] decoded
//   HWDATA             : write data (data phase)
//   Btn                : raw buttons, 0 = pressed
//   HRDATA             : read data
//   HREADYOUT          : always 1, zero wait states
//   IRQ                : registered IE & FIFO non-empty
// Registers: 0x0 STATUS, 0x4 EVENT (pop on read), 0x8 CTRL, 0xC LEVEL.
// ---------------------------------------------------------------------------
module ahb_button_event_queue
   import button_pkg::*;
#(
   parameter int N_BTN      = 4,
   parameter int DEB_CYC    = 900,
   parameter int LONG_CYC   = 32000,
   parameter int GAP_CYC    = 16000,
   parameter int FIFO_DEPTH = 8
) (
   input  logic             HCLK,
   input  logic             HRESETn,
   input  logic             HSEL,
   input  logic             HREADY,
   input  logic             HWRITE,
   input  logic [1:0]       HTRANS,
   input  logic [2:0]       HSIZE,
   input  logic [31:0]      HADDR,
   input  logic [31:0]      HWDATA,
   input  logic [N_BTN-1:0] Btn,
   output logic [31:0]      HRDATA,
   output logic             HREADYOUT,
   output logic             IRQ
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [N_BTN-1:0] level;
   logic [N_BTN-1:0] pend_valid;
   logic [N_BTN-1:0] lost;
   logic [N_BTN-1:0] grant;
   evt_code_t        pend_code [N_BTN];

   logic             push_req;
   logic [2:0]       push_chan;
   evt_code_t        push_code;
   logic             push;
   logic             pop;

   evt_entry_t       fifo_mem [FIFO_DEPTH];
   logic [PTR_W-1:0] wr_ptr_q;
   logic [PTR_W-1:0] rd_ptr_q;
   logic [CNT_W-1:0] count_q;
   logic             empty;
   logic             full;
   evt_entry_t       head;
   logic [4:0]       count_ext;
   logic [3:0]       count_field;

   logic             ap_valid_q;
   logic             ap_write_q;
   logic [1:0]       ap_addr_q;
   logic             ctrl_wr;
   logic             clr_ovf;

   logic             ie_q;
   logic             fifo_ovf_q;
   logic             ovf;
   logic             irq_q;
   logic             unused_inputs;

   genvar g;
   generate
      for (g = 0; g < N_BTN; g++) begin : g_chan
         button_channel #(
            .DEB_CYC  (DEB_CYC),
            .LONG_CYC (LONG_CYC),
            .GAP_CYC  (GAP_CYC)
         ) u_chan (
            .HCLK       (HCLK),
            .HRESETn    (HRESETn),
            .btn_n      (Btn[g]),
            .accept     (grant[g]),
            .clr_lost   (clr_ovf),
            .level      (level[g]),
            .pend_valid (pend_valid[g]),
            .pend_code  (pend_code[g]),
            .lost       (lost[g])
         );
      end
   endgenerate

   // Fixed-priority arbiter: the lowest-numbered channel with a pending
   // event is granted. The grant is given even when the FIFO is full, so a
   // dropped event leaves its slot and is recorded in OVF instead.
   always_comb begin
      grant     = '0;
      push_req  = 1'b0;
      push_chan = '0;
      push_code = NONE;
      for (int i = 0; i < N_BTN; i++) begin
         if (pend_valid[i] && !push_req) begin
            grant[i]  = 1'b1;
            push_req  = 1'b1;
            push_chan = 3'(i);
            push_code = pend_code[i];
         end
      end
   end

   assign empty = (count_q == '0);
   assign full  = (count_q == CNT_W'(FIFO_DEPTH));
   assign head  = fifo_mem[rd_ptr_q];

   // A pop frees a slot in the same cycle, so a push into a full FIFO still
   // lands when software is reading at that moment.
   assign pop  = ap_valid_q && !ap_write_q && HREADY &&
                 (ap_addr_q == REG_EVENT) && !empty;
   assign push = push_req && (!full || pop);

   // FIFO storage carries no reset; validity is tracked by the count.
   always_ff @(posedge HCLK) begin
      if (push) begin
         fifo_mem[wr_ptr_q].chan <= push_chan;
         fifo_mem[wr_ptr_q].code <= push_code;
      end
   end

   // FIFO pointers wrap naturally because the depth is a power of two; the
   // count saturates at the depth since a push into a full FIFO is refused.
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push) begin
            wr_ptr_q <= wr_ptr_q + 1'b1;
         end
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + 1'b1;
         end
         case ({push, pop})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

   // AHB address phase capture. Only accepted when the bus is ready, so a
   // stalled transfer elsewhere never repeats our side effects.
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         ap_valid_q <= 1'b0;
         ap_write_q <= 1'b0;
         ap_addr_q  <= REG_STATUS;
      end else if (HREADY) begin
         ap_valid_q <= HSEL && HTRANS[1];
         ap_write_q <= HWRITE;
         ap_addr_q  <= HADDR[3:2];
      end
   end

   assign ctrl_wr = ap_valid_q && ap_write_q && HREADY && (ap_addr_q == REG_CTRL);
   assign clr_ovf = ctrl_wr && HWDATA[1];

   // Control and overflow state. FIFO overflow is sticky; a new overflow in
   // the same cycle as the W1C clear keeps the flag set.
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         ie_q       <= 1'b0;
         fifo_ovf_q <= 1'b0;
         irq_q      <= 1'b0;
      end else begin
         if (ctrl_wr) begin
            ie_q <= HWDATA[0];
         end
         if (push_req && full && !pop) begin
            fifo_ovf_q <= 1'b1;
         end else if (clr_ovf) begin
            fifo_ovf_q <= 1'b0;
         end
         irq_q <= ie_q && !empty;
      end
   end

   assign ovf = fifo_ovf_q || (|lost);

   // The STATUS count field is four bits wide; a full 16-deep FIFO is shown
   // as 15 rather than wrapping to zero.
   assign count_ext   = 5'(count_q);
   assign count_field = count_ext[4] ? 4'hF : count_ext[3:0];

   // Read mux, combinational on the registered address during a read data
   // phase; zero otherwise and for all unused bits.
   always_comb begin
      HRDATA = '0;
      if (ap_valid_q && !ap_write_q) begin
         case (ap_addr_q)
            REG_STATUS: begin
               HRDATA[0]   = !empty;
               HRDATA[1]   = ovf;
               HRDATA[7:4] = count_field;
            end
            REG_EVENT: begin
               if (!empty) begin
                  HRDATA = pack_event(head);
               end
            end
            REG_CTRL: begin
               HRDATA[0] = ie_q;
            end
            REG_LEVEL: begin
               HRDATA[N_BTN-1:0] = level;
            end
            default: begin
               HRDATA = '0;
            end
         endcase
      end
   end

   assign HREADYOUT = 1'b1;
   assign IRQ       = irq_q;

   assign unused_inputs = ^{HSIZE, HTRANS[0], HADDR[31:4], HADDR[1:0], HWDATA[31:2]};

endmodule

// File: tb/tb_ahb_button_event_queue.sv
// ---------------------------------------------------------------------------
// tb_ahb_button_event_queue
// Directed bench for ahb_button_event_queue. Timing parameters are scaled
// down (DEB 30, LONG 1000, GAP 500) so every scenario runs in a few
// thousand cycles; durations below keep the same ratios as the field values.
// ---------------------------------------------------------------------------
module tb_ahb_button_event_queue;

   localparam int N_BTN      = 4;
   localparam int DEB_CYC    = 30;
   localparam int LONG_CYC   = 1000;
   localparam int GAP_CYC    = 500;
   localparam int FIFO_DEPTH = 8;
   localparam int SETTLE     = GAP_CYC + DEB_CYC + 50;

   localparam logic [3:0] A_STATUS = 4'h0;
   localparam logic [3:0] A_EVENT  = 4'h4;
   localparam logic [3:0] A_CTRL   = 4'h8;
   localparam logic [3:0] A_LEVEL  = 4'hC;

   logic             HCLK = 1'b0;
   logic             HRESETn;
   logic             HSEL;
   logic             HREADY;
   logic             HWRITE;
   logic [1:0]       HTRANS;
   logic [2:0]       HSIZE;
   logic [31:0]      HADDR;
   logic [31:0]      HWDATA;
   logic [N_BTN-1:0] Btn;
   logic [31:0]      HRDATA;
   logic             HREADYOUT;
   logic             IRQ;

   int               checkCount = 0;
   int               errorCount = 0;
   logic [31:0]      rdData;

   ahb_button_event_queue #(
      .N_BTN      (N_BTN),
      .DEB_CYC    (DEB_CYC),
      .LONG_CYC   (LONG_CYC),
      .GAP_CYC    (GAP_CYC),
      .FIFO_DEPTH (FIFO_DEPTH)
   ) dut (
      .HCLK      (HCLK),
      .HRESETn   (HRESETn),
      .HSEL      (HSEL),
      .HREADY    (HREADY),
      .HWRITE    (HWRITE),
      .HTRANS    (HTRANS),
      .HSIZE     (HSIZE),
      .HADDR     (HADDR),
      .HWDATA    (HWDATA),
      .Btn       (Btn),
      .HRDATA    (HRDATA),
      .HREADYOUT (HREADYOUT),
      .IRQ       (IRQ)
   );

   always #5 HCLK = ~HCLK;

   // Hard stop in case something stalls the sequence.
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checkCount++;
      if (observed !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s: observed=0x%08h expected=0x%08h", tag, observed, expected);
      end
   endtask

   task automatic waitCycles(input int n);
      repeat (n) @(posedge HCLK);
   endtask

   // Drive the buttons (mask bit 1 = pressed) and hold for a number of cycles.
   task automatic applyStimulus(input logic [N_BTN-1:0] pressMask, input int cycles);
      @(posedge HCLK);
      #1;
      Btn = ~pressMask;
      repeat (cycles) @(posedge HCLK);
   endtask

   task automatic busRead(input logic [3:0] addr, output logic [31:0] data);
      @(posedge HCLK);
      #1;
      HSEL   = 1'b1;
      HTRANS = 2'b10;
      HWRITE = 1'b0;
      HADDR  = {28'd0, addr};
      @(posedge HCLK);
      #1;
      HSEL   = 1'b0;
      HTRANS = 2'b00;
      @(negedge HCLK);
      data = HRDATA;
   endtask

   task automatic busWrite(input logic [3:0] addr, input logic [31:0] data);
      @(posedge HCLK);
      #1;
      HSEL   = 1'b1;
      HTRANS = 2'b10;
      HWRITE = 1'b1;
      HADDR  = {28'd0, addr};
      @(posedge HCLK);
      #1;
      HSEL   = 1'b0;
      HTRANS = 2'b00;
      HWRITE = 1'b0;
      HWDATA = data;
      @(posedge HCLK);
      #1;
   endtask

   task automatic readCheck(input string tag, input logic [3:0] addr,
                            input logic [31:0] expected);
      logic [31:0] d;
      busRead(addr, d);
      checkOutput(tag, d, expected);
   endtask

   initial begin
      HRESETn = 1'b0;
      HSEL    = 1'b0;
      HREADY  = 1'b1;
      HWRITE  = 1'b0;
      HTRANS  = 2'b00;
      HSIZE   = 3'b010;
      HADDR   = '0;
      HWDATA  = '0;
      Btn     = '1;

      // Reset values
      waitCycles(3);
      @(negedge HCLK);
      checkOutput("rst_hrdata", HRDATA, 32'h0);
      checkOutput("rst_irq", {31'd0, IRQ}, 32'h0);
      checkOutput("hreadyout", {31'd0, HREADYOUT}, 32'h1);
      HRESETn = 1'b1;
      readCheck("rst_status", A_STATUS, 32'h0);
      readCheck("rst_level", A_LEVEL, 32'h0);
      readCheck("rst_ctrl", A_CTRL, 32'h0);
      readCheck("rst_event_empty", A_EVENT, 32'h0);

      // Short press on ch1 with interrupts enabled
      busWrite(A_CTRL, 32'h1);
      readCheck("ctrl_ie", A_CTRL, 32'h1);
      applyStimulus(4'b0010, 100);
      readCheck("short_level", A_LEVEL, 32'h2);
      applyStimulus(4'b0000, 300);
      readCheck("short_midgap_status", A_STATUS, 32'h0);
      checkOutput("short_midgap_irq", {31'd0, IRQ}, 32'h0);
      waitCycles(SETTLE - 300);
      @(negedge HCLK);
      checkOutput("short_irq", {31'd0, IRQ}, 32'h1);
      readCheck("short_status", A_STATUS, 32'h11);
      readCheck("short_event", A_EVENT, 32'h8000_0101);
      waitCycles(3);
      @(negedge HCLK);
      checkOutput("short_irq_after_pop", {31'd0, IRQ}, 32'h0);
      readCheck("short_status_after_pop", A_STATUS, 32'h0);

      // Double press on ch0
      applyStimulus(4'b0001, 100);
      applyStimulus(4'b0000, 150);
      applyStimulus(4'b0001, 100);
      applyStimulus(4'b0000, SETTLE);
      readCheck("double_status", A_STATUS, 32'h11);
      readCheck("double_event", A_EVENT, 32'h8000_0002);
      readCheck("double_no_short", A_EVENT, 32'h0);

      // Long press on ch2; release must not add anything
      applyStimulus(4'b0100, 950);
      readCheck("long_before", A_STATUS, 32'h0);
      applyStimulus(4'b0100, 150);
      readCheck("long_after", A_STATUS, 32'h11);
      applyStimulus(4'b0000, SETTLE);
      readCheck("long_release_status", A_STATUS, 32'h11);
      readCheck("long_event", A_EVENT, 32'h8000_0203);

      // Bounce on ch1 then a steady press: exactly one SHORT
      for (int i = 0; i < 10; i++) begin
         applyStimulus(4'b0010, 10);
         applyStimulus(4'b0000, 10);
      end
      readCheck("bounce_level", A_LEVEL, 32'h0);
      applyStimulus(4'b0010, 100);
      applyStimulus(4'b0000, SETTLE);
      readCheck("bounce_status", A_STATUS, 32'h11);
      readCheck("bounce_event", A_EVENT, 32'h8000_0101);

      // Lone glitch shorter than the debounce time: no event
      applyStimulus(4'b0010, 15);
      applyStimulus(4'b0000, SETTLE);
      readCheck("glitch_status", A_STATUS, 32'h0);

      // ch3 and ch0 emit in the same cycle: ch0 pops first
      applyStimulus(4'b1001, 100);
      applyStimulus(4'b0000, SETTLE);
      readCheck("simul_status", A_STATUS, 32'h21);
      readCheck("simul_first", A_EVENT, 32'h8000_0001);
      readCheck("simul_second", A_EVENT, 32'h8000_0301);

      // Overflow: 9 events into 8 entries
      for (int r = 0; r < 2; r++) begin
         applyStimulus(4'b1111, 100);
         applyStimulus(4'b0000, SETTLE);
      end
      readCheck("ovf_count8", A_STATUS, 32'h81);
      applyStimulus(4'b0001, 100);
      applyStimulus(4'b0000, SETTLE);
      readCheck("ovf_status", A_STATUS, 32'h83);
      @(negedge HCLK);
      checkOutput("ovf_irq", {31'd0, IRQ}, 32'h1);
      busWrite(A_EVENT, 32'hFFFF_FFFF);
      readCheck("ro_write_ignored", A_STATUS, 32'h83);
      busWrite(A_CTRL, 32'h3);
      readCheck("ovf_cleared", A_STATUS, 32'h81);
      readCheck("ovf_ctrl_ie", A_CTRL, 32'h1);
      for (int r = 0; r < 2; r++) begin
         for (int c = 0; c < 4; c++) begin
            busRead(A_EVENT, rdData);
            checkOutput($sformatf("drain_r%0d_c%0d", r, c), rdData,
                        32'h8000_0001 | (32'(c) << 8));
         end
      end
      readCheck("drain_empty", A_STATUS, 32'h0);

      // Reset in the middle of a press with an event queued
      applyStimulus(4'b1000, 100);
      applyStimulus(4'b0000, SETTLE);
      readCheck("pre_rst_status", A_STATUS, 32'h11);
      applyStimulus(4'b0100, 100);
      readCheck("pre_rst_level", A_LEVEL, 32'h4);
      @(negedge HCLK);
      HRESETn = 1'b0;
      waitCycles(2);
      @(negedge HCLK);
      checkOutput("midrst_irq", {31'd0, IRQ}, 32'h0);
      checkOutput("midrst_hrdata", HRDATA, 32'h0);
      Btn = '1;
      waitCycles(3);
      @(negedge HCLK);
      HRESETn = 1'b1;
      readCheck("post_rst_status", A_STATUS, 32'h0);
      readCheck("post_rst_level", A_LEVEL, 32'h0);
      readCheck("post_rst_ctrl", A_CTRL, 32'h0);
      applyStimulus(4'b0000, SETTLE);
      readCheck("post_rst_no_event", A_STATUS, 32'h0);
      @(negedge HCLK);
      checkOutput("post_rst_irq", {31'd0, IRQ}, 32'h0);

      $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
      $finish;
   end

endmodule
